// File: rtl/rmt_action_pkg.sv
// Shared match-action definitions: action word layout, ALU opcodes and the
// issue FSM state encoding, reused by both the issue stage and the ALU.
package rmt_action_pkg;

   localparam int OPC_HI  = 24;
   localparam int OPC_LO  = 21;
   localparam int SRC1_HI = 20;
   localparam int SRC1_LO = 18;
   localparam int SRC2_HI = 17;
   localparam int SRC2_LO = 15;
   localparam int DST_HI  = 14;
   localparam int DST_LO  = 12;
   localparam int IMM_HI  = 11;
   localparam int IMM_LO  = 0;

   localparam int OPC_W = 4;
   localparam int IDX_W = 3;
   localparam int IMM_W = 12;

   localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
   localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0001;
   localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0010;
   localparam logic [OPC_W-1:0] OPC_ADDI = 4'b0011;
   localparam logic [OPC_W-1:0] OPC_SUBI = 4'b0100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      OUTPUT = 2'd3
   } issue_state_t;

   function automatic logic opc_is_alu(input logic [OPC_W-1:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_ADDI) || (opc == OPC_SUBI);
   endfunction

   function automatic logic opc_uses_imm(input logic [OPC_W-1:0] opc);
      return (opc == OPC_ADDI) || (opc == OPC_SUBI);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Link between the issue stage and the ALU. Handshake: the ALU takes the action
// and operands in the single cycle action_valid_out is 1 (no ready; the ALU always
// accepts), and returns one result by holding container_in_valid for one cycle.
interface alu_issue_if #(
   parameter int DATA_WIDTH = 48,
   parameter int ACTION_LEN = 25
);
   logic [ACTION_LEN-1:0] action_out;
   logic                  action_valid_out;
   logic [DATA_WIDTH-1:0] operand_1_out;
   logic [DATA_WIDTH-1:0] operand_2_out;
   logic [DATA_WIDTH-1:0] container_in;
   logic                  container_in_valid;

   modport master (
      output action_out, action_valid_out, operand_1_out, operand_2_out,
      input  container_in, container_in_valid
   );

   modport slave (
      input  action_out, action_valid_out, operand_1_out, operand_2_out,
      output container_in, container_in_valid
   );
endinterface

// File: rtl/phv_cont_sel.sv
// Picks one container out of a packed PHV; an index beyond the container
// count yields zero.
module phv_cont_sel
   import rmt_action_pkg::*;
#(
   parameter int DATA_WIDTH = 48,
   parameter int NUM_CONT   = 8
) (
   input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
   input  logic [IDX_W-1:0]               idx,
   output logic [DATA_WIDTH-1:0]          cont
);

   always_comb begin
      cont = '0;
      for (int i = 0; i < NUM_CONT; i++) begin
         if (int'(idx) == i) cont = phv[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: captures a PHV plus action, hands operands to the external ALU,
// writes the result back into the destination container and releases the PHV.
module alu_issue
   import rmt_action_pkg::*;
#(
   parameter int DATA_WIDTH = 48,
   parameter int NUM_CONT   = 8,
   parameter int ACTION_LEN = 25,
   parameter int ALU_LAT    = 3,
   parameter int TIMEOUT    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
   input  logic                           phv_in_valid,
   output logic                           phv_in_ready,
   input  logic [ACTION_LEN-1:0]          action_in,
   alu_issue_if.master                    alu,
   output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
   output logic                           phv_out_valid,
   input  logic                           phv_out_ready,
   output logic                           err_timeout,
   output logic                           err_unsup,
   output logic [31:0]                    issue_cnt,
   output issue_state_t                   fsm_state
);

   localparam int LIMIT = ALU_LAT + TIMEOUT;
   localparam int CNT_W = $clog2(LIMIT + 1);

   issue_state_t                         state, state_nx;
   logic [NUM_CONT-1:0][DATA_WIDTH-1:0]  phv_q;
   logic [ACTION_LEN-1:0]                act_q;
   logic [DATA_WIDTH-1:0]                op1_q, op2_q, sel1, sel2, op2_nx;
   logic [CNT_W-1:0]                     wait_cnt;
   logic [31:0]                          issue_cnt_q;
   logic                                 err_unsup_q;
   logic [OPC_W-1:0]                     opc;
   logic [IDX_W-1:0]                     dst_idx;
   logic                                 accept, alu_op, take_result, timed_out;

   assign opc         = action_in[OPC_HI:OPC_LO];
   assign alu_op      = opc_is_alu(opc);
   assign accept      = phv_in_valid && phv_in_ready;
   assign dst_idx     = act_q[DST_HI:DST_LO];
   assign take_result = (state == WAIT) && alu.container_in_valid;
   assign timed_out   = (state == WAIT) && !alu.container_in_valid &&
                        (wait_cnt == CNT_W'(LIMIT));

   // Operands are taken from the incoming PHV at capture, so a later
   // write-back to src1/src2 cannot disturb what the ALU was given.
   phv_cont_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel1 (
      .phv  (phv_in),
      .idx  (action_in[SRC1_HI:SRC1_LO]),
      .cont (sel1)
   );

   phv_cont_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel2 (
      .phv  (phv_in),
      .idx  (action_in[SRC2_HI:SRC2_LO]),
      .cont (sel2)
   );

   assign op2_nx = opc_uses_imm(opc) ?
                   {{(DATA_WIDTH-IMM_W){1'b0}}, action_in[IMM_HI:IMM_LO]} : sel2;

   always_comb begin
      state_nx             = state;
      phv_in_ready         = 1'b0;
      phv_out_valid        = 1'b0;
      alu.action_valid_out = 1'b0;
      err_timeout          = 1'b0;
      unique case (state)
         IDLE: begin
            phv_in_ready = rst_n;
            if (phv_in_valid && rst_n) state_nx = alu_op ? ISSUE : OUTPUT;
         end
         ISSUE: begin
            alu.action_valid_out = 1'b1;
            state_nx             = WAIT;
         end
         WAIT: begin
            err_timeout = timed_out;
            if (take_result || timed_out) state_nx = OUTPUT;
         end
         OUTPUT: begin
            phv_out_valid = 1'b1;
            if (phv_out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phv_q       <= '0;
         act_q       <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         wait_cnt    <= '0;
         issue_cnt_q <= '0;
         err_unsup_q <= 1'b0;
      end else begin
         state       <= state_nx;
         err_unsup_q <= accept && !alu_op && (opc != OPC_NOP);
         if (accept) begin
            phv_q <= phv_in;
            act_q <= action_in;
            op1_q <= sel1;
            op2_q <= op2_nx;
         end
         if (state == ISSUE) begin
            wait_cnt    <= '0;
            issue_cnt_q <= issue_cnt_q + 32'd1;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         // Results arriving outside WAIT never reach here, so late ones are dropped.
         if (take_result && (int'(dst_idx) < NUM_CONT)) phv_q[dst_idx] <= alu.container_in;
      end
   end

   assign alu.action_out    = act_q;
   assign alu.operand_1_out = op1_q;
   assign alu.operand_2_out = op2_q;
   assign phv_out           = (state == OUTPUT) ? phv_q : '0;
   assign err_unsup         = err_unsup_q;
   assign issue_cnt         = issue_cnt_q;
   assign fsm_state         = state;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: the ALU side is driven by hand with
// precomputed results, and every observation is an immediate assertion.
module tb_alu_issue;
  import rmt_action_pkg::*;

  localparam int DW = 48;
  localparam int NC = 8;
  localparam int AL = 25;
  localparam int PW = NC * DW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NC-1:0][DW-1:0] phv_in;
  logic                phv_in_valid;
  logic                phv_in_ready;
  logic [AL-1:0]       action_in;
  logic [PW-1:0]       phv_out;
  logic                phv_out_valid;
  logic                phv_out_ready;
  logic                err_timeout;
  logic                err_unsup;
  logic [31:0]         issue_cnt;
  issue_state_t        fsm_state;

  alu_issue_if #(.DATA_WIDTH(DW), .ACTION_LEN(AL)) alu ();

  alu_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phv_in        (phv_in),
    .phv_in_valid  (phv_in_valid),
    .phv_in_ready  (phv_in_ready),
    .action_in     (action_in),
    .alu           (alu.master),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .phv_out_ready (phv_out_ready),
    .err_timeout   (err_timeout),
    .err_unsup     (err_unsup),
    .issue_cnt     (issue_cnt),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NC-1:0][DW-1:0] p_a, p_b, p_c, exp_phv;
  logic [AL-1:0] act_add, act_subi, act_nop, act_bad;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NC-1:0][DW-1:0] p, input logic [AL-1:0] a);
    phv_in       = p;
    action_in    = a;
    phv_in_valid = 1'b1;
    tick();
    phv_in_valid = 1'b0;
  endtask

  task automatic alu_result(input logic [DW-1:0] v);
    alu.container_in       = v;
    alu.container_in_valid = 1'b1;
    tick();
    alu.container_in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      p_a[i] = 48'hA0 + 48'(i);
      p_b[i] = 48'h1234_0000_0000 + 48'(i * 3);
      p_c[i] = 48'hC0C0_0000_0000 | 48'(i);
    end
    p_a[2] = 48'h10;
    p_a[5] = 48'h20;
    p_b[0] = 48'h5;
    act_add  = {OPC_ADD,  3'd2, 3'd5, 3'd7, 12'h000};
    act_subi = {OPC_SUBI, 3'd0, 3'd3, 3'd0, 12'h007};
    act_nop  = {OPC_NOP,  3'd1, 3'd2, 3'd3, 12'h0FF};
    act_bad  = {4'b1111,  3'd1, 3'd2, 3'd3, 12'h0FF};

    rst_n                  = 1'b1;
    phv_in                 = '0;
    phv_in_valid           = 1'b0;
    action_in              = '0;
    phv_out_ready          = 1'b0;
    alu.container_in       = '0;
    alu.container_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_in_ready",  phv_in_ready, 0);
    chk("rst_out_valid", phv_out_valid, 0);
    chk("rst_act_valid", alu.action_valid_out, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_phv_out",   phv_out, 0);
    chk("rst_state",     fsm_state, IDLE);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", phv_in_ready, 1);

    // Add with 4 cycles of backpressure on the output
    send(p_a, act_add);
    chk("add_act_valid", alu.action_valid_out, 1);
    chk("add_op1",       alu.operand_1_out, 48'h10);
    chk("add_op2",       alu.operand_2_out, 48'h20);
    chk("add_action",    alu.action_out, act_add);
    chk("add_in_ready",  phv_in_ready, 0);
    tick();
    chk("add_act_once",  alu.action_valid_out, 0);
    chk("add_cnt1",      issue_cnt, 1);
    tick();
    tick();
    chk("add_not_early", phv_out_valid, 0);
    alu_result(48'h30);
    exp_phv    = p_a;
    exp_phv[7] = 48'h30;
    chk("add_out_valid", phv_out_valid, 1);
    chk("add_phv_out",   phv_out, exp_phv);
    chk("add_no_tmo",    err_timeout, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid",    phv_out_valid, 1);
      chk("bp_stable",   phv_out, exp_phv);
      chk("bp_in_ready", phv_in_ready, 0);
    end
    phv_out_ready = 1'b1;
    tick();
    chk("bp_done_valid", phv_out_valid, 0);
    chk("bp_done_ready", phv_in_ready, 1);

    // Subi with dst == src1
    send(p_b, act_subi);
    chk("subi_op1", alu.operand_1_out, 48'h5);
    chk("subi_op2", alu.operand_2_out, 48'h7);
    tick();
    tick();
    tick();
    alu_result(48'hFFFF_FFFF_FFFE);
    exp_phv    = p_b;
    exp_phv[0] = 48'hFFFF_FFFF_FFFE;
    chk("subi_valid",   phv_out_valid, 1);
    chk("subi_phv_out", phv_out, exp_phv);
    tick();
    chk("subi_cnt2",  issue_cnt, 2);
    chk("subi_ready", phv_in_ready, 1);

    // Nop and unsupported opcode: echo one cycle after accept
    send(p_c, act_nop);
    chk("nop_valid",     phv_out_valid, 1);
    chk("nop_phv",       phv_out, p_c);
    chk("nop_act_valid", alu.action_valid_out, 0);
    chk("nop_unsup",     err_unsup, 0);
    tick();
    chk("nop_ready",     phv_in_ready, 1);
    send(p_b, act_bad);
    chk("bad_valid",     phv_out_valid, 1);
    chk("bad_phv",       phv_out, p_b);
    chk("bad_unsup",     err_unsup, 1);
    chk("bad_act_valid", alu.action_valid_out, 0);
    tick();
    chk("bad_unsup_end", err_unsup, 0);
    chk("bad_cnt",       issue_cnt, 2);

    // Silent ALU: timeout 11 cycles after entering WAIT
    send(p_a, act_add);
    phv_out_ready = 1'b0;
    repeat (11) tick();
    chk("tmo_early",     err_timeout, 0);
    tick();
    chk("tmo_pulse",     err_timeout, 1);
    chk("tmo_not_out",   phv_out_valid, 0);
    tick();
    chk("tmo_pulse_end", err_timeout, 0);
    chk("tmo_valid",     phv_out_valid, 1);
    chk("tmo_phv",       phv_out, p_a);
    alu.container_in       = 48'hDEAD;
    alu.container_in_valid = 1'b1;
    tick();
    chk("late_ignored",  phv_out, p_a);
    phv_out_ready = 1'b1;
    tick();
    tick();
    alu.container_in_valid = 1'b0;
    send(p_c, act_nop);
    chk("late_next_phv", phv_out, p_c);
    tick();
    chk("tmo_cnt3",      issue_cnt, 3);

    // Reset while waiting on the ALU
    send(p_a, act_add);
    tick();
    tick();
    chk("mid_state", fsm_state, WAIT);
    alu.container_in       = 48'h99;
    alu.container_in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",  phv_in_ready, 0);
    chk("mrst_out_valid", phv_out_valid, 0);
    chk("mrst_phv_out",   phv_out, 0);
    chk("mrst_op1",       alu.operand_1_out, 0);
    chk("mrst_action",    alu.action_out, 0);
    chk("mrst_cnt",       issue_cnt, 0);
    chk("mrst_tmo",       err_timeout, 0);
    chk("mrst_state",     fsm_state, IDLE);
    tick();
    rst_n = 1'b1;
    alu.container_in_valid = 1'b0;
    tick();
    chk("mrel_ready", phv_in_ready, 1);
    chk("mrel_valid", phv_out_valid, 0);
    send(p_a, act_add);
    tick();
    tick();
    tick();
    alu_result(48'h30);
    exp_phv    = p_a;
    exp_phv[7] = 48'h30;
    chk("fresh_valid", phv_out_valid, 1);
    chk("fresh_phv",   phv_out, exp_phv);
    chk("fresh_cnt",   issue_cnt, 1);
    tick();
    chk("fresh_done",  phv_in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 48, the container width.
REQ-002 The module SHALL take parameter NUM_CONT, default 8, the number of PHV containers held.
REQ-003 The module SHALL take parameter ACTION_LEN, default 25, the action word width.
REQ-004 The module SHALL take parameter ALU_LAT, default 3, the ALU result latency in cycles.
REQ-005 The module SHALL take parameter TIMEOUT, default 8, the extra wait cycles before the ALU is declared lost.
REQ-006 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 phv_in  in  NUM_CONT*DATA_WIDTH  packed containers, container 0 in the LSBs; phv_in_valid  in  1; phv_in_ready  out  1.
REQ-008 action_in  in  ACTION_LEN  fields: [24:21] opcode, [20:18] src1 idx, [17:15] src2 idx, [14:12] dst idx, [11:0] imm.
REQ-009 action_out  out  ACTION_LEN; action_valid_out  out  1; operand_1_out, operand_2_out  out  DATA_WIDTH each (all to ALU).
REQ-010 container_in  in  DATA_WIDTH; container_in_valid  in  1 (result from ALU).
REQ-011 phv_out  out  NUM_CONT*DATA_WIDTH; phv_out_valid  out  1; phv_out_ready  in  1.
REQ-012 err_timeout  out  1 pulse; err_unsup  out  1 pulse; issue_cnt  out  32  count of actions issued to the ALU.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, WAIT, OUTPUT.
REQ-014 phv_in_ready SHALL be 1 only in IDLE; the PHV and action are captured on the edge where phv_in_valid and phv_in_ready are both 1.
REQ-015 Opcodes 0001/0010 (add/sub) SHALL select op1 = cont[src1] and op2 = cont[src2].
REQ-016 Opcodes 0011/0100 (addi/subi) SHALL select op1 = cont[src1] and op2 = imm, zero-extended to DATA_WIDTH.
REQ-017 Opcode 0000 (nop) SHALL go IDLE -> OUTPUT, with no ALU issue and the PHV unmodified.
REQ-018 Any other opcode SHALL behave as nop and pulse err_unsup for 1 cycle.
REQ-019 For a supported opcode, the FSM SHALL go IDLE -> ISSUE on capture.
REQ-020 In ISSUE, action_valid_out SHALL be 1 for exactly one cycle, with action_out and the operands registered; ISSUE -> WAIT; issue_cnt increments (wraps at 2^32).
REQ-021 In WAIT, a cycle counter SHALL start at 0.
REQ-022 When container_in_valid is sampled in WAIT, the block SHALL write container_in into cont[dst] and go to OUTPUT.
REQ-023 If the WAIT counter reaches ALU_LAT+TIMEOUT without a result, err_timeout SHALL pulse, the PHV SHALL go to OUTPUT unmodified, and the FSM SHALL go to OUTPUT.
REQ-024 container_in_valid outside WAIT SHALL be ignored (late result discarded).
REQ-025 In OUTPUT, phv_out_valid SHALL be held at 1 with phv_out stable until phv_out_ready; on the handshake, OUTPUT -> IDLE.
REQ-026 Nominal latency SHALL be: accept edge T; action_valid_out during cycle T+1; result ALU_LAT cycles later; phv_out_valid the following cycle (5 cycles with defaults; nop: 1 cycle).
REQ-027 dst equal to src1 or src2 SHALL be permitted; operands are read from the captured copy before write-back.
REQ-028 Arithmetic SHALL be performed only in the ALU; this block does no arithmetic beyond the immediate zero-extension.
REQ-029 Index fields SHALL be 3 bits; an index >= NUM_CONT selects zero as the operand and drops the write-back.

Reset
REQ-030 On rst_n low, at any time, the FSM SHALL return to IDLE and all outputs SHALL be 0 except phv_in_ready, which is 1 after reset release.
REQ-031 Reset mid-operation SHALL discard the captured PHV and any in-flight ALU result; issue_cnt returns to 0.

Structure
REQ-032 Opcode constants, action field positions and the FSM state enum SHALL reside in shared package rmt_action_pkg, reused by the ALU.
REQ-033 Container selection SHALL be a sub-module phv_cont_sel (index in, container out, zero for out-of-range indices), instantiated twice.

Verification
REQ-034 Add: cont2=0x10, cont5=0x20, opcode 0001, src1=2, src2=5, dst=7, ALU model returns 0x30 -> phv_out cont7=0x30, others unchanged, phv_out_valid 5 cycles after accept.
REQ-035 Subi: cont0=0x5, opcode 0100, imm=0x007 -> operand_2_out=0x7; model result 0xFFFFFFFFFFFE written to dst.
REQ-036 Nop, and opcode 1111: PHV is echoed 1 cycle after accept; action_valid_out never 1; err_unsup pulses for 1111 only.
REQ-037 ALU model silent: err_timeout pulses 11 cycles after the WAIT entry; PHV unmodified; a result injected later does not alter the next PHV.
REQ-038 Backpressure: phv_out_ready low for 4 cycles -> phv_out stable and phv_in_ready stays 0 until the handshake.
REQ-039 rst_n asserted during WAIT -> all outputs 0 at once; after release, a fresh add completes correctly and issue_cnt = 1.
